fll_trim_controller: RTL

- Parametrised frequency-locked-loop controller; successor to the fixed 26-bit DLL controller.
- Runs on the DCO output clock. Each cycle it counts DCO clocks per period of the reference `osc`, compares the count against `div`, and steps a thermometer trim code with a saturating coarse/fine gain.
- Adds a lock detector, an osc-loss timeout and an observable period measurement.
- Sits between the ring-oscillator trim input and the top-level FLL wrapper. It replaces the fixed controller and the wrapper's trim mux.

---
 rtl/fll_trim_controller.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fll_trim_controller.sv
// Frequency-locked-loop trim controller: counts DCO cycles per reference
// period and steps a saturating thermometer trim code toward the target divider.
module fll_trim_controller #(
  parameter int TRIM_W      = 26,
  parameter int DIV_W       = 5,
  parameter int CNT_W       = 8,
  parameter int TOL         = 0,
  parameter int LOCK_N      = 4,
  parameter int INIT_CODE   = 13,
  parameter int COARSE_TH   = 4,
  parameter int COARSE_STEP = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              osc,
  input  logic [DIV_W-1:0]  div,
  input  logic              dco,
  input  logic [TRIM_W-1:0] ext_trim,
  output logic [TRIM_W-1:0] trim,
  output logic              locked,
  output logic [CNT_W-1:0]  period_out,
  output logic              meas_valid,
  output logic              osc_lost
);
  localparam int CODE_W = $clog2(TRIM_W + 1);
  localparam int LCK_W  = $clog2(LOCK_N + 1);
  localparam logic [CODE_W-1:0] INIT_C  = CODE_W'(INIT_CODE);
  localparam logic [LCK_W-1:0]  LOCK_C  = LCK_W'(LOCK_N);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  function automatic logic [TRIM_W-1:0] thermo(input logic [CODE_W-1:0] c);
    logic [TRIM_W-1:0] t;
    for (int i = 0; i < TRIM_W; i++) t[i] = (i < int'(c));
    return t;
  endfunction

  logic              s1, s2, s3;
  logic              osc_rise, starved, loop_run, armed, in_band;
  logic [CNT_W-1:0]  cnt;
  logic [CODE_W-1:0] code, code_nxt;
  logic [LCK_W-1:0]  lock_cnt, lock_nxt;
  logic [TRIM_W-1:0] trim_q;
  int                meas_i, tgt_i, err_i, step_i, code_i;

  assign osc_rise = s2 & ~s3;
  assign starved  = ~osc_rise & (cnt == CNT_MAX);
  assign loop_run = enable & ~dco & (div != '0);
  assign trim     = dco ? ext_trim : trim_q;

  // NOTE: every always_comb output is assigned up front so no path can infer a latch.
  always_comb begin
    meas_i   = int'(period_out);
    tgt_i    = int'(div);
    err_i    = (meas_i >= tgt_i) ? meas_i - tgt_i : tgt_i - meas_i;
    step_i   = (err_i > COARSE_TH) ? COARSE_STEP : 1;
    code_i   = int'(code);
    in_band  = (err_i <= TOL);
    if (meas_i > tgt_i + TOL)
      code_i = (code_i + step_i > TRIM_W) ? TRIM_W : code_i + step_i;
    else if (meas_i + TOL < tgt_i)
      code_i = (code_i < step_i) ? 0 : code_i - step_i;
    code_nxt = CODE_W'(code_i);
    lock_nxt = (lock_cnt == LOCK_C) ? lock_cnt : lock_cnt + LCK_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      cnt        <= '0;
      armed      <= 1'b0;
      period_out <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      osc_lost   <= 1'b0;
      lock_cnt   <= '0;
      code       <= INIT_C;
      trim_q     <= thermo(INIT_C);
    end else begin
      s1         <= osc;
      s2         <= s1;
      s3         <= s2;
      trim_q     <= thermo(code);
      meas_valid <= 1'b0;
      if (!enable) begin
        cnt      <= '0;
        armed    <= 1'b0;
        lock_cnt <= '0;
        locked   <= 1'b0;
        osc_lost <= 1'b0;
        code     <= INIT_C;
      end else begin
        // The first edge after reset, enable or osc loss only arms the counter.
        if (osc_rise) begin
          cnt      <= CNT_W'(1);
          osc_lost <= 1'b0;
          armed    <= 1'b1;
          if (armed) begin
            period_out <= cnt;
            meas_valid <= 1'b1;
          end
        end else if (cnt == CNT_MAX) begin
          osc_lost <= 1'b1;
          armed    <= 1'b0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end

        if (!loop_run || starved) begin
          locked   <= 1'b0;
          lock_cnt <= '0;
        end else if (meas_valid) begin
          if (in_band) begin
            lock_cnt <= lock_nxt;
            if (lock_nxt == LOCK_C) locked <= 1'b1;
          end else begin
            code     <= code_nxt;
            lock_cnt <= '0;
            locked   <= 1'b0;
          end
        end
      end
    end
  end
endmodule
